// File: rtl/regfile_pkg.sv
// Shared register-file constants for the write arbiter and its arbiter core.
// Widths follow the RV32 integer register file.
package regfile_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    // Architectural zero register: writes to it are accepted but discarded.
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    // Width and ceiling of the dropped-x0-write statistic.
    localparam int              DROP_CNT_W   = 16;
    localparam logic [15:0]     DROP_CNT_MAX = 16'hFFFF;

    // Saturating increment used by the x0 drop counter.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
        if (value == DROP_CNT_MAX) begin
            return value;
        end
        return value + 16'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: picks the first asserted request at or above
// the pointer, wrapping around to index 0 when nothing above it is asserted.
// Purely combinational; the owner keeps the pointer.
module rr_arbiter #(
    parameter int N_REQ = 2,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [N_REQ-1:0] w_hi_mask;   // requesters at or above the pointer
    logic [N_REQ-1:0] w_hi_req;    // requests in the upper (preferred) window
    logic [N_REQ-1:0] w_sel_req;   // window actually searched

    // Thermometer mask of positions at or after the pointer.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign w_hi_mask[gi] = (IDX_W'(gi) >= i_ptr);
        end
    endgenerate

    assign w_hi_req  = i_req & w_hi_mask;
    assign w_sel_req = (|w_hi_req) ? w_hi_req : i_req;
    assign o_any     = |i_req;

    // Lowest set bit of the chosen window wins; scanning downward lets the
    // lowest index overwrite any higher candidate.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_sel_req[k]) begin
                o_grant    = '0;
                o_grant[k] = 1'b1;
                o_idx      = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: several write requesters share one
// register-file write port under round-robin priority. Writes to x0 are
// accepted and dropped, and counted in a saturating statistic.
module regfile_write_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W,
    localparam int SRC_W = $clog2(N_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [N_REQ-1:0][DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]               req_ready,
    output logic                           wr_ena,
    output logic [ADDR_W-1:0]              wr_addr,
    output logic [DATA_W-1:0]              wr_data,
    output logic [SRC_W-1:0]               wr_src,
    output logic [15:0]                    x0_drop_cnt
);

    import regfile_pkg::*;

    // Architectural state.
    logic [SRC_W-1:0]   r_rr_ptr;
    logic               r_wr_ena;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic [SRC_W-1:0]   r_wr_src;
    logic [15:0]        r_x0_cnt;

    // Arbitration results.
    logic [N_REQ-1:0]   w_grant;
    logic [SRC_W-1:0]   w_idx;
    logic               w_any;
    logic               w_fire;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_is_x0;
    logic [SRC_W-1:0]   w_ptr_next;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Grants are suppressed during reset so nothing is consumed and the
    // requester simply retries once reset is released.
    assign req_ready  = rst ? '0 : w_grant;
    assign w_fire     = w_any & ~rst;

    assign w_sel_addr = req_addr[w_idx];
    assign w_sel_data = req_data[w_idx];
    assign w_is_x0    = (w_sel_addr == ADDR_W'(REG_ZERO));

    // Pointer moves to the slot just after the winner, wrapping at N_REQ.
    assign w_ptr_next = (w_idx == SRC_W'(N_REQ - 1)) ? '0 : (w_idx + SRC_W'(1));

    // Round-robin pointer: advances only on an accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_fire) begin
            r_rr_ptr <= w_ptr_next;
        end
    end

    // Registered write port: one-cycle latency, fields hold when idle or on
    // a dropped x0 write so the register file sees stable values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ena  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_src  <= '0;
        end else begin
            r_wr_ena <= w_fire & ~w_is_x0;
            if (w_fire && !w_is_x0) begin
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
                r_wr_src  <= w_idx;
            end
        end
    end

    // Saturating count of accepted writes aimed at x0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x0_cnt <= '0;
        end else if (w_fire && w_is_x0) begin
            r_x0_cnt <= sat_inc(r_x0_cnt);
        end
    end

    assign wr_ena      = r_wr_ena;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign wr_src      = r_wr_src;
    assign x0_drop_cnt = r_x0_cnt;

endmodule
